// File: rtl/axis_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : taxi_axis_if
// Brief    : AXI4-Stream interface bundle with source and sink modports.
// Revision : 1.0 - initial release
// ============================================================================
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_tx
// Brief    : AXI4-Stream byte sink serialised as an asynchronous UART frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_tx #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    taxi_axis_if.snk              s_axis,
    output logic                  Txd,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  Busy,
    output logic [15:0]           StatusFrames
);

    localparam int               BIT_W       = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] c_last_data = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] c_last_stop = BIT_W'(STOP_BITS - 1);
    localparam logic             c_odd       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_txd;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [BIT_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_shift;
    logic                  r_parity;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [15:0]           r_frames;
    logic                  r_run;

    state_t                w_state_nxt;
    logic                  w_txd_nxt;
    logic [PRESCALE_W-1:0] w_cnt_nxt;
    logic [BIT_W-1:0]      w_idx_nxt;
    logic [DATA_W-1:0]     w_shift_nxt;
    logic                  w_parity_nxt;
    logic [PRESCALE_W-1:0] w_prescale_nxt;
    logic [15:0]           w_frames_nxt;
    logic [PRESCALE_W-1:0] w_p;
    logic                  w_bit_end;
    logic                  w_stop_last;
    logic                  w_ready;
    logic                  w_take;

    assign w_p         = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
    assign w_bit_end   = (r_cnt == '0);
    assign w_stop_last = (r_state == S_STOP) && w_bit_end && (r_idx == c_last_stop);
    // r_run holds tready low until the first edge after reset is released
    assign w_ready     = r_run && ((r_state == S_IDLE) || w_stop_last);
    assign w_take      = w_ready && s_axis.tvalid;

    assign s_axis.tready = w_ready;
    assign Txd           = r_txd;
    assign Busy          = (r_state != S_IDLE);
    assign StatusFrames  = r_frames;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_txd      <= 1'b1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_prescale <= PRESCALE_W'(1);
            r_frames   <= '0;
            r_run      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_txd      <= w_txd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_prescale <= w_prescale_nxt;
            r_frames   <= w_frames_nxt;
            r_run      <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_txd_nxt      = r_txd;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_prescale_nxt = r_prescale;
        w_frames_nxt   = r_frames;

        if (!w_bit_end) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = r_prescale - 1'b1;
                    w_idx_nxt   = '0;
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = r_prescale - 1'b1;
                    if (r_idx == c_last_data) begin
                        w_idx_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_txd_nxt   = r_parity;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_txd_nxt   = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = r_prescale - 1'b1;
                    w_idx_nxt   = '0;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == c_last_stop) begin
                        w_frames_nxt = r_frames + 16'd1;
                        w_state_nxt  = S_IDLE;
                        w_txd_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_cnt_nxt = r_prescale - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase

        // Accept from IDLE or the final stop cycle; the latter chains frames with no gap
        if (w_take) begin
            w_state_nxt    = S_START;
            w_txd_nxt      = 1'b0;
            w_shift_nxt    = s_axis.tdata;
            w_parity_nxt   = (^s_axis.tdata) ^ c_odd;
            w_prescale_nxt = w_p;
            w_cnt_nxt      = w_p - 1'b1;
            w_idx_nxt      = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_uart_tx
// Brief    : Directed bench for axis_uart_tx over four parity/stop configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_uart_tx;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         p;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic [15:0] Prescale;
    logic [7:0]  td [4];
    logic        tv [4];
    logic        tr [4];
    logic        txd [4];
    logic        busy [4];
    logic [15:0] frames [4];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    bit   act [4];
    int   mcyc [4];
    bit   ok [4];
    exp_t cur [4];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instance 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stops
    for (genvar g = 0; g < 4; g++) begin : g_dut
        taxi_axis_if #(.DATA_W(8)) ax ();
        assign ax.tdata  = td[g];
        assign ax.tvalid = tv[g];
        assign ax.tkeep  = 1'b1;
        assign ax.tlast  = 1'b1;
        assign ax.tid    = 1'b0;
        assign ax.tdest  = 1'b0;
        assign ax.tuser  = 1'b0;
        assign tr[g]     = ax.tready;

        axis_uart_tx #(
            .DATA_W    (8),
            .PRESCALE_W(16),
            .PARITY    ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) u_dut (
            .Clk         (Clk),
            .Rst         (Rst),
            .s_axis      (ax),
            .Txd         (txd[g]),
            .Prescale    (Prescale),
            .Busy        (busy[g]),
            .StatusFrames(frames[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pmode(int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int flen(int i, int p);
        return (1 + 8 + ((pmode(i) != 0) ? 1 : 0) + ((i == 3) ? 2 : 1)) * p;
    endfunction

    function automatic logic exp_bit(int i, logic [7:0] d, int p, int c);
        int b;
        b = c / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pmode(i) != 0 && b == 9) return (^d) ^ (pmode(i) == 2);
        return 1'b1;
    endfunction

    // Scoreboard monitor: entries are pushed on handshake, popped at start bit, and
    // each frame is checked cycle by cycle for Txd, Busy and tready.
    always @(negedge Clk) begin
        bit found;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (!Rst) begin
                act[i] = 1'b0;
            end else begin
                if (!act[i] && txd[i] === 1'b0) begin
                    found = 1'b0;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (sb[k].inst == i) begin
                            cur[i] = sb[k];
                            sb.delete(k);
                            found = 1'b1;
                            break;
                        end
                    end
                    check("sb_start_expected", {31'd0, found}, 32'd1);
                    act[i]  = 1'b1;
                    mcyc[i] = 0;
                    ok[i]   = 1'b1;
                end
                if (act[i]) begin
                    if (txd[i] !== exp_bit(i, cur[i].data, cur[i].p, mcyc[i])) ok[i] = 1'b0;
                    if (busy[i] !== 1'b1) ok[i] = 1'b0;
                    if (tr[i] !== (mcyc[i] == flen(i, cur[i].p) - 1)) ok[i] = 1'b0;
                    mcyc[i]++;
                    if (mcyc[i] == flen(i, cur[i].p)) begin
                        check($sformatf("frame_wave_i%0d_d%02h", i, cur[i].data), {31'd0, ok[i]}, 32'd1);
                        act[i] = 1'b0;
                    end
                end
                if (tv[i] === 1'b1 && tr[i] === 1'b1) begin
                    e.inst = i;
                    e.data = td[i];
                    e.p    = (Prescale == 16'd0) ? 1 : int'(Prescale);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit hold, output int hs);
        td[i] = d;
        tv[i] = 1'b1;
        hs    = -1;
        for (int w = 0; w < 400; w++) begin
            if (tr[i] === 1'b1) begin
                @(posedge Clk);
                hs = int'($time / 10);
                #1;
                if (!hold) tv[i] = 1'b0;
                return;
            end
            tick(1);
        end
        check("handshake_timeout", 32'd0, 32'd1);
        tv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, output int n);
        n = 0;
        while (busy[i] !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic frame_probe(input int i, input logic [7:0] d, input int off,
                               input logic expv, input int f);
        int hs;
        send(i, d, 1'b0, hs);
        check("start_txd", {31'd0, txd[i]}, 32'd0);
        check("start_busy", {31'd0, busy[i]}, 32'd1);
        check("start_tready", {31'd0, tr[i]}, 32'd0);
        tick(off - 1);
        check("probe_txd", {31'd0, txd[i]}, {31'd0, expv});
        tick(f - off);
        check("last_stop_tready", {31'd0, tr[i]}, 32'd1);
        tick(1);
        check("after_frame_busy", {31'd0, busy[i]}, 32'd0);
        check("after_frame_txd", {31'd0, txd[i]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1, h2, n;
        for (int i = 0; i < 4; i++) begin
            td[i]  = 8'h00;
            tv[i]  = 1'b0;
            act[i] = 1'b0;
        end
        Prescale = 16'd4;
        Rst      = 1'b0;
        tick(3);
        check("rst_txd", {31'd0, txd[0]}, 32'd1);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_tready", {31'd0, tr[0]}, 32'd0);
        check("rst_frames", {16'd0, frames[0]}, 32'd0);
        Rst = 1'b1;
        check("rel_tready_pre_edge", {31'd0, tr[0]}, 32'd0);
        tick(1);
        check("rel_tready", {31'd0, tr[0]}, 32'd1);

        // 0xA5 at P=4: bit0 occupies offsets 5..8
        frame_probe(0, 8'hA5, 5, 1'b1, 40);
        check("frames_after_a5", {16'd0, frames[0]}, 32'd1);

        // Held tvalid, back-to-back at P=2
        Prescale = 16'd2;
        send(0, 8'h00, 1'b1, h1);
        send(0, 8'hFF, 1'b0, h2);
        check("b2b_period", h2 - h1, 32'd20);
        wait_idle(0, 200, n);
        check("b2b_second_len", n, 32'd20);
        check("frames_after_b2b", {16'd0, frames[0]}, 32'd3);

        // Parity bit occupies offsets 28..30 at P=3
        Prescale = 16'd3;
        frame_probe(1, 8'h07, 28, 1'b1, 33);
        frame_probe(2, 8'h07, 28, 1'b0, 33);

        // Two stop bits at P=3, held tvalid
        send(3, 8'h3C, 1'b1, h1);
        tick(29);
        check("stop2_first_end_tready", {31'd0, tr[3]}, 32'd0);
        check("stop2_first_end_txd", {31'd0, txd[3]}, 32'd1);
        send(3, 8'h81, 1'b0, h2);
        check("stop2_period", h2 - h1, 32'd33);
        wait_idle(3, 200, n);
        check("stop2_second_len", n, 32'd33);

        // Prescale 0 acts as 1
        Prescale = 16'd0;
        frame_probe(0, 8'h01, 2, 1'b1, 10);

        // Prescale change mid-frame applies to the next frame only
        Prescale = 16'd4;
        send(0, 8'h5A, 1'b1, h1);
        tick(10);
        Prescale = 16'd8;
        send(0, 8'hC3, 1'b0, h2);
        check("presc_first_period", h2 - h1, 32'd40);
        wait_idle(0, 300, n);
        check("presc_second_len", n, 32'd80);

        // Reset during data bit 3 (offsets 17..20 at P=4)
        Prescale = 16'd4;
        send(0, 8'hF7, 1'b0, h1);
        tick(17);
        check("mid_bit3_txd", {31'd0, txd[0]}, 32'd0);
        Rst = 1'b0;
        tick(1);
        check("midrst_txd", {31'd0, txd[0]}, 32'd1);
        check("midrst_busy", {31'd0, busy[0]}, 32'd0);
        check("midrst_tready", {31'd0, tr[0]}, 32'd0);
        check("midrst_frames", {16'd0, frames[0]}, 32'd0);
        Rst = 1'b1;
        tick(1);
        check("midrst_rel_tready", {31'd0, tr[0]}, 32'd1);
        frame_probe(0, 8'h55, 5, 1'b1, 40);
        check("frames_after_55", {16'd0, frames[0]}, 32'd1);

        tick(2);
        check("sb_empty", sb.size(), 32'd0);
        check("mon_idle", {28'd0, act[3], act[2], act[1], act[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
